// File: rtl/bot_updt_requester.sv
// Requester side of the Rojobot-to-CPU 4-phase update handshake (clk75 domain).
// Optional macro ACK_TIMEOUT_EN adds a REQ-phase timeout with a sticky timeout_err flag.
module bot_updt_requester #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk75,
  input  logic              reset_n,
  input  logic              upd_tick,
  input  logic [DATA_W-1:0] bot_data_in,
  input  logic              IO_INT_ACK,
  output logic              IO_BotUpdt,
  output logic [DATA_W-1:0] bot_data_out,
  output logic              busy,
  output logic [CNT_W-1:0]  missed_cnt,
  output logic              timeout_err
);

  if (TIMEOUT_CYC < 1) begin : g_param_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

  state_e            state_q;
  logic              ack_meta_q, ack_s_q;
  logic              pending_q, req_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  miss_q, miss_inc;
  logic              launch;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_err_q;
  logic            tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
`endif

  // IO_INT_ACK comes from the 50 MHz domain; plain 2-flop synchronizer.
  always_ff @(posedge clk75 or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= IO_INT_ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_comb begin
    miss_inc = (&miss_q) ? miss_q : miss_q + 1'b1;
    launch   = ((state_q == StIdle) && upd_tick) ||
               ((state_q == StWaitLow) && !ack_s_q && (pending_q || upd_tick));
  end

  always_ff @(posedge clk75 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      data_q    <= '0;
      pending_q <= 1'b0;
      miss_q    <= '0;
`ifdef ACK_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else if (launch) begin
      // Sample at launch time so a deferred request carries the newest data.
      data_q    <= bot_data_in;
      req_q     <= 1'b1;
      pending_q <= 1'b0;
      state_q   <= StReq;
`ifdef ACK_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StReq: begin
          if (upd_tick) begin
            if (pending_q) miss_q <= miss_inc;
            else           pending_q <= 1'b1;
          end
          if (ack_s_q) begin
            req_q   <= 1'b0;
            state_q <= StWaitLow;
          end
`ifdef ACK_TIMEOUT_EN
          else if (tmo_hit) begin
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            state_q   <= StIdle;
            tmo_err_q <= 1'b1;
            if (pending_q || upd_tick) miss_q <= miss_inc;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StWaitLow: begin
          if (!ack_s_q) begin
            state_q <= StIdle;
          end else if (upd_tick) begin
            if (pending_q) miss_q <= miss_inc;
            else           pending_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign IO_BotUpdt   = req_q;
  assign bot_data_out = data_q;
  assign busy         = (state_q != StIdle);
  assign missed_cnt   = miss_q;
`ifdef ACK_TIMEOUT_EN
  assign timeout_err  = tmo_err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bot_updt_requester.sv
// Self-checking bench for bot_updt_requester: vector table plus scoreboard of expected snapshots.
module tb_bot_updt_requester;

  logic        clk75 = 1'b0;
  logic        reset_n = 1'b0;
  logic        upd_tick = 1'b0;
  logic [31:0] bot_data_in = '0;
  logic        IO_INT_ACK = 1'b0;
  logic        IO_BotUpdt;
  logic [31:0] bot_data_out;
  logic        busy;
  logic [7:0]  missed_cnt;
  logic        timeout_err;

  always #5 clk75 = ~clk75;

  bot_updt_requester #(
    .DATA_W      (32),
    .CNT_W       (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk75        (clk75),
    .reset_n      (reset_n),
    .upd_tick     (upd_tick),
    .bot_data_in  (bot_data_in),
    .IO_INT_ACK   (IO_INT_ACK),
    .IO_BotUpdt   (IO_BotUpdt),
    .bot_data_out (bot_data_out),
    .busy         (busy),
    .missed_cnt   (missed_cnt),
    .timeout_err  (timeout_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    int          delay;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk75);
    #1;
  endtask

  task automatic sb_compare(input string name);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got launch %0h expected none queued", name, bot_data_out);
    end else begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (bot_data_out !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, bot_data_out, e);
      end
    end
  endtask

  // Idle launch: one-edge latency to IO_BotUpdt and the snapshot.
  task automatic launch_tick(input logic [31:0] d, input logic [31:0] e, input string name);
    bot_data_in = d;
    upd_tick    = 1'b1;
    exp_q.push_back(e);
    step();
    upd_tick    = 1'b0;
    check({name, "_req_rise"}, IO_BotUpdt, 1);
    sb_compare({name, "_snap"});
  endtask

  task automatic handshake(output int rise_n, output int fall_n);
    IO_INT_ACK = 1'b1;
    rise_n = 0;
    while (IO_BotUpdt && rise_n < 10) begin
      step();
      rise_n++;
    end
    IO_INT_ACK = 1'b0;
    fall_n = 0;
    while (busy && fall_n < 10) begin
      step();
      fall_n++;
    end
  endtask

  initial begin
    int r, f, n;
    bit busy_drop;

    vecs[0] = '{32'h1234_5678, 20, 32'h1234_5678};
    vecs[1] = '{32'hFFFF_FFFF, 0,  32'hFFFF_FFFF};
    vecs[2] = '{32'h0000_0001, 5,  32'h0000_0001};
    vecs[3] = '{32'h80A5_5A01, 11, 32'h80A5_5A01};

    // Reset and idle
    repeat (3) step();
    reset_n = 1'b1;
    repeat (100) step();
    check("rst_req", IO_BotUpdt, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed_cnt, 0);
    check("rst_data", bot_data_out, 0);
    check("rst_tmo", timeout_err, 0);

    // Table-driven basic transfers
    for (int i = 0; i < 4; i++) begin
      launch_tick(vecs[i].data, vecs[i].exp_out, "vec");
      bot_data_in = ~vecs[i].data;
      repeat (vecs[i].delay) step();
      check("vec_hold_req", IO_BotUpdt, 1);
      check("vec_hold_snap", bot_data_out, {32'h0, vecs[i].exp_out});
      handshake(r, f);
      check_rng("vec_ack_to_req_fall", r, 2, 3);
      check_rng("vec_ackfall_to_idle", f, 2, 3);
    end
    check("vec_missed", missed_cnt, 0);

    // Pending tick during REQ relaunches with data sampled at launch
    launch_tick(32'h1234_5678, 32'h1234_5678, "pend1");
    repeat (3) step();
    bot_data_in = 32'h1111_1111;
    upd_tick    = 1'b1;
    exp_q.push_back(32'hAABB_CCDD);
    step();
    upd_tick    = 1'b0;
    bot_data_in = 32'hAABB_CCDD;
    repeat (3) step();
    IO_INT_ACK = 1'b1;
    n = 0;
    while (IO_BotUpdt && n < 10) begin
      step();
      n++;
    end
    check_rng("pend_req_fall", n, 2, 3);
    IO_INT_ACK = 1'b0;
    busy_drop = 1'b0;
    n = 0;
    while (!IO_BotUpdt && n < 10) begin
      step();
      n++;
      if (!busy) busy_drop = 1'b1;
    end
    check_rng("pend_relaunch", n, 2, 3);
    check("pend_busy_held", busy_drop, 0);
    sb_compare("pend_snap");
    check("pend_missed", missed_cnt, 0);
    handshake(r, f);
    check_rng("pend_done", f, 2, 3);

    // Spurious ack while idle
    IO_INT_ACK = 1'b1;
    repeat (6) step();
    check("spur_busy", busy, 0);
    check("spur_req", IO_BotUpdt, 0);
    check("spur_missed", missed_cnt, 0);
    IO_INT_ACK = 1'b0;
    repeat (4) step();

    // Ack arrival and tick on the same edge in REQ
    launch_tick(32'hCAFE_0001, 32'hCAFE_0001, "simul");
    IO_INT_ACK = 1'b1;
    step();
    step();
    bot_data_in = 32'hBEEF_0002;
    upd_tick    = 1'b1;
    exp_q.push_back(32'hBEEF_0002);
    step();
    upd_tick    = 1'b0;
    check("simul_req_fall", IO_BotUpdt, 0);
    check("simul_busy", busy, 1);
    IO_INT_ACK = 1'b0;
    n = 0;
    while (!IO_BotUpdt && n < 10) begin
      step();
      n++;
    end
    check_rng("simul_relaunch", n, 2, 3);
    sb_compare("simul_snap");
    check("simul_missed", missed_cnt, 0);
    handshake(r, f);
    check_rng("simul_done", f, 2, 3);

    // Overrun: 300 ticks with REQ held
    launch_tick(32'h5555_AAAA, 32'h5555_AAAA, "ovr");
    upd_tick = 1'b1;
    repeat (300) step();
    upd_tick = 1'b0;
    bot_data_in = 32'h0F0F_0F0F;
    check("ovr_missed_sat", missed_cnt, 8'hFF);
    check("ovr_req_held", IO_BotUpdt, 1);
    check("ovr_snap_held", bot_data_out, 32'h5555_AAAA);
    exp_q.push_back(32'h0F0F_0F0F);
    IO_INT_ACK = 1'b1;
    n = 0;
    while (IO_BotUpdt && n < 10) begin
      step();
      n++;
    end
    IO_INT_ACK = 1'b0;
    n = 0;
    while (!IO_BotUpdt && n < 10) begin
      step();
      n++;
    end
    check_rng("ovr_pending_relaunch", n, 2, 3);
    sb_compare("ovr_snap");

    // Asynchronous reset mid-REQ
    @(posedge clk75);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_req", IO_BotUpdt, 0);
    check("arst_busy", busy, 0);
    check("arst_missed", missed_cnt, 0);
    check("arst_data", bot_data_out, 0);
    check("arst_tmo", timeout_err, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("arst_idle", busy, 0);
    check("arst_req_after", IO_BotUpdt, 0);

`ifdef ACK_TIMEOUT_EN
    launch_tick(32'h7777_0000, 32'h7777_0000, "tmo");
    n = 0;
    while (IO_BotUpdt && n < 40) begin
      upd_tick = (n == 4);
      step();
      n++;
    end
    upd_tick = 1'b0;
    check("tmo_req_cycles", n, 16);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_missed", missed_cnt, 1);
    repeat (3) step();
    launch_tick(32'h8888_1111, 32'h8888_1111, "tmo_ok");
    handshake(r, f);
    check_rng("tmo_ok_req_fall", r, 2, 3);
    check("tmo_err_sticky", timeout_err, 1);
`else
    launch_tick(32'h7777_0000, 32'h7777_0000, "notmo");
    repeat (40) step();
    check("notmo_req_held", IO_BotUpdt, 1);
    check("notmo_err", timeout_err, 0);
    handshake(r, f);
    check_rng("notmo_done", f, 2, 3);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
